// File: rtl/usb_pkg.sv
// usb_pkg: definitions shared by the full-speed bit-stuffing NRZI transmitter.
//   state_t       transmitter FSM states
//   SYNC_PATTERN  raw SYNC field, sent LSB-first (seven 0s then a 1)
//   line_t        {dp, dm} line-state encodings (J, K, SE0)
//   LEVEL_J       value of the NRZI level register that means J
//   level_line()  maps an NRZI level to its {dp, dm} line state
package usb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    DATA  = 3'd2,
    STUFF = 3'd3,
    EOP0  = 3'd4,
    EOP1  = 3'd5,
    EOPJ  = 3'd6
  } state_t;

  localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;

  typedef enum logic [1:0] {
    LINE_SE0 = 2'b00,
    LINE_K   = 2'b01,
    LINE_J   = 2'b10
  } line_t;

  localparam logic LEVEL_J = 1'b1;

  function automatic line_t level_line(input logic level);
    return (level == LEVEL_J) ? LINE_J : LINE_K;
  endfunction

endpackage

// File: rtl/usb_bitstuff_nrzi_tx_if.sv
// usb_bitstuff_nrzi_tx_if: bit-serial handshake between the upstream packet
// serializer (master) and the bit-stuffing NRZI transmitter (slave).
//   in_valid  serializer presents a packet bit
//   in_bit    packet bit, LSB-first as received
//   in_last   marks the final bit of the packet
//   in_ready  transmitter takes the bit on a rising clk edge when both high
interface usb_bitstuff_nrzi_tx_if;
  logic in_valid;
  logic in_bit;
  logic in_last;
  logic in_ready;

  modport master (output in_valid, output in_bit, output in_last, input in_ready);
  modport slave  (input in_valid, input in_bit, input in_last, output in_ready);
endinterface

// File: rtl/usb_nrzi_drv.sv
// usb_nrzi_drv: NRZI level register and registered full-speed line outputs.
//   clk, rst_b  clock, asynchronous active-low reset
//   raw         raw bit for this cycle: 0 toggles the level, 1 holds it
//   se0         drive SE0 this cycle; the NRZI level is left untouched
//   drive       transmitter active; when low the line idles at J with oe=0
//               and the level register returns to J
//   dp, dm, oe  registered line levels and transceiver output enable
//   level       current NRZI level (LEVEL_J means J), used by the FSM to
//               choose the raw bit that lands the line on J after SE0
module usb_nrzi_drv
  import usb_pkg::*;
(
  input  logic clk,
  input  logic rst_b,
  input  logic raw,
  input  logic se0,
  input  logic drive,
  output logic dp,
  output logic dm,
  output logic oe,
  output logic level
);

  logic level_next;

  assign level_next = raw ? level : ~level;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      level    <= LEVEL_J;
      {dp, dm} <= LINE_J;
      oe       <= 1'b0;
    end else if (!drive) begin
      level    <= LEVEL_J;
      {dp, dm} <= LINE_J;
      oe       <= 1'b0;
    end else if (se0) begin
      {dp, dm} <= LINE_SE0;
      oe       <= 1'b1;
    end else begin
      level    <= level_next;
      {dp, dm} <= level_line(level_next);
      oe       <= 1'b1;
    end
  end

endmodule

// File: rtl/usb_bitstuff_nrzi_tx.sv
// usb_bitstuff_nrzi_tx: full-speed USB transmit back end. Frames a bit-serial
// packet with SYNC and EOP, inserts a stuffed 0 after STUFF_LIMIT consecutive
// ones, and NRZI-encodes the result onto dp/dm. One bit time per clk cycle.
//   clk, rst_b  clock, asynchronous active-low reset
//   in_if       slave side of the in_valid/in_bit/in_last/in_ready handshake
//   dp, dm, oe  registered line levels and output enable
//   busy        high whenever the FSM is not IDLE
//   err         one-cycle pulse when the serializer underruns mid-packet
// The line is one cycle behind the FSM: the state of cycle t decides the raw
// bit, which the driver registers onto dp/dm at the end of that cycle.
module usb_bitstuff_nrzi_tx
  import usb_pkg::*;
#(
  parameter int STUFF_LIMIT = 6
) (
  input  logic                        clk,
  input  logic                        rst_b,
  usb_bitstuff_nrzi_tx_if.slave       in_if,
  output logic                        dp,
  output logic                        dm,
  output logic                        oe,
  output logic                        busy,
  output logic                        err
);

  localparam int ONES_W = $clog2(STUFF_LIMIT + 1);
  localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'(STUFF_LIMIT);

  state_t            state_reg;
  logic [2:0]        sync_cnt_reg;
  logic [ONES_W-1:0] ones_reg;
  logic [ONES_W-1:0] ones_inc;
  logic              stuff_last_reg;
  logic              in_ready_reg;
  logic              busy_reg;
  logic              err_reg;
  logic              stuff_hit;

  logic raw;
  logic se0;
  logic drive;
  logic level;

  // Saturating increment keeps the counter inside 0..STUFF_LIMIT.
  assign ones_inc  = (ones_reg == ONES_MAX) ? ones_reg : ones_reg + ONES_W'(1);
  assign stuff_hit = in_if.in_bit && (ones_inc == ONES_MAX);

  assign in_if.in_ready = in_ready_reg;
  assign busy           = busy_reg;
  assign err            = err_reg;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg      <= IDLE;
      sync_cnt_reg   <= 3'd0;
      ones_reg       <= '0;
      stuff_last_reg <= 1'b0;
      in_ready_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          ones_reg       <= '0;
          sync_cnt_reg   <= 3'd0;
          stuff_last_reg <= 1'b0;
          if (in_if.in_valid) begin
            state_reg <= SYNC;
            busy_reg  <= 1'b1;
          end
        end

        SYNC: begin
          // SYNC bits feed the ones counter, so it leaves SYNC at 1.
          ones_reg     <= SYNC_PATTERN[sync_cnt_reg] ? ones_inc : '0;
          sync_cnt_reg <= sync_cnt_reg + 3'd1;
          if (sync_cnt_reg == 3'd7) begin
            state_reg    <= DATA;
            in_ready_reg <= 1'b1;
          end
        end

        DATA: begin
          if (in_if.in_valid) begin
            if (!in_if.in_bit || stuff_hit) begin
              ones_reg <= '0;
            end else begin
              ones_reg <= ones_inc;
            end
            if (stuff_hit) begin
              // The stuffed 0 always goes out, even after the last bit.
              state_reg      <= STUFF;
              stuff_last_reg <= in_if.in_last;
              in_ready_reg   <= 1'b0;
            end else if (in_if.in_last) begin
              state_reg    <= EOP0;
              in_ready_reg <= 1'b0;
            end
          end else begin
            // Underrun: abort the packet with an EOP.
            err_reg      <= 1'b1;
            state_reg    <= EOP0;
            in_ready_reg <= 1'b0;
          end
        end

        STUFF: begin
          if (stuff_last_reg) begin
            state_reg <= EOP0;
          end else begin
            state_reg    <= DATA;
            in_ready_reg <= 1'b1;
          end
        end

        EOP0: state_reg <= EOP1;
        EOP1: state_reg <= EOPJ;

        EOPJ: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end

        default: begin
          state_reg    <= IDLE;
          in_ready_reg <= 1'b0;
          busy_reg     <= 1'b0;
        end
      endcase
    end
  end

  // Raw bit / SE0 / drive request for the driver in the current state.
  always_comb begin
    raw   = 1'b1;
    se0   = 1'b0;
    drive = 1'b1;
    case (state_reg)
      IDLE:       drive = 1'b0;
      SYNC:       raw   = SYNC_PATTERN[sync_cnt_reg];
      // On underrun the abort cycle holds the line (raw 1) before SE0.
      DATA:       raw   = in_if.in_valid ? in_if.in_bit : 1'b1;
      STUFF:      raw   = 1'b0;
      EOP0, EOP1: se0   = 1'b1;
      // Hold if already at J, toggle if at K: either way the line ends on J.
      EOPJ:       raw   = (level == LEVEL_J);
      default:    drive = 1'b0;
    endcase
  end

  usb_nrzi_drv u_drv (
    .clk   (clk),
    .rst_b (rst_b),
    .raw   (raw),
    .se0   (se0),
    .drive (drive),
    .dp    (dp),
    .dm    (dm),
    .oe    (oe),
    .level (level)
  );

endmodule

// File: tb/tb_usb_bitstuff_nrzi_tx.sv
// tb_usb_bitstuff_nrzi_tx: directed bench for usb_bitstuff_nrzi_tx. Each packet
// is recorded as the string of line states seen while oe is high
// (J, K, 0 = SE0) and compared against hand-derived sequences.
module tb_usb_bitstuff_nrzi_tx;

  logic clk = 1'b0;
  logic rst_b;
  logic dp, dm, oe, busy, err;

  usb_bitstuff_nrzi_tx_if bus ();

  usb_bitstuff_nrzi_tx #(.STUFF_LIMIT(6)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .in_if (bus),
    .dp    (dp),
    .dm    (dm),
    .oe    (oe),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Results of the most recent run_packet call.
  string line_s;
  int    busy_cnt, gap_cnt, err_cnt, err_pos, extra_cnt;
  bit    timed_out, reset_hit;

  function automatic string line_char(input logic p, input logic m);
    if (p && !m) return "J";
    if (!p && m) return "K";
    if (!p && !m) return "0";
    return "X";
  endfunction

  // Sends n bits (LSB-first from bits) starting from IDLE and records the
  // line until oe falls. use_last marks the final bit; without it in_valid
  // drops after n bits (underrun). hold keeps in_valid high after the last
  // bit. rst_at >= 0 pulls rst_b low once rst_at bits have been accepted.
  task automatic run_packet(input logic [15:0] bits, input int n, input bit use_last,
                            input bit hold, input int rst_at);
    int idx;
    bit seen_oe, data_on, rdy_prev, done;
    idx = 0; seen_oe = 0; data_on = 0; done = 0;
    line_s = ""; busy_cnt = 0; gap_cnt = 0; err_cnt = 0; err_pos = -1;
    extra_cnt = 0; timed_out = 0; reset_hit = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_bit   = bits[0];
    bus.in_last  = use_last && (n == 1);
    rdy_prev     = bus.in_ready;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      if (bus.in_valid && rdy_prev) begin
        if (idx < n) idx++;
        else extra_cnt++;
      end
      if (!oe && seen_oe) begin
        done = 1;
      end else begin
        if (busy) busy_cnt++;
        if (err) begin
          err_cnt++;
          err_pos = line_s.len();
        end
        if (oe) begin
          seen_oe = 1;
          line_s = {line_s, line_char(dp, dm)};
        end
        if (bus.in_ready) data_on = 1;
        if (data_on && !bus.in_ready && busy && idx < n) gap_cnt++;
        if (rst_at >= 0 && data_on && idx == rst_at) begin
          rst_b = 1'b0;
          #1;
          reset_hit = 1;
          done = 1;
        end else begin
          if (idx < n) begin
            bus.in_valid = 1'b1;
            bus.in_bit   = bits[idx];
            bus.in_last  = use_last && (idx == n - 1);
          end else if (hold) begin
            bus.in_valid = 1'b1;
            bus.in_bit   = 1'b1;
            bus.in_last  = 1'b1;
          end else begin
            bus.in_valid = 1'b0;
            bus.in_bit   = 1'b0;
            bus.in_last  = 1'b0;
          end
          rdy_prev = bus.in_ready;
        end
      end
    end
    if (!done) timed_out = 1;
    $display("pkt n=%0d line=%s busy=%0d err=%0d gaps=%0d", n, line_s, busy_cnt, err_cnt, gap_cnt);
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.in_last = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({dp, dm} !== 2'b10) begin n_bad++; $display("FAIL reset_line: got %b expected 10", {dp, dm}); end
    n_cmp++; if (oe !== 1'b0) begin n_bad++; $display("FAIL reset_oe: got %b expected 0", oe); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", err); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b expected 0", bus.in_ready); end
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if ({oe, busy, bus.in_ready, dp, dm} !== 5'b00010) begin
      n_bad++; $display("FAIL idle_hold: got oe/busy/rdy/dp/dm=%b expected 00010", {oe, busy, bus.in_ready, dp, dm});
    end
    $display("txn reset done");
  endtask

  task automatic test_single_bit();
    run_packet(16'h0000, 1, 1'b1, 1'b0, -1);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL single_timeout: got timeout expected finish"); end
    n_cmp++; if (line_s != "KJKJKJKKJ00J") begin n_bad++; $display("FAIL single_line: got %s expected KJKJKJKKJ00J", line_s); end
    n_cmp++; if (busy_cnt != 12) begin n_bad++; $display("FAIL single_busy: got %0d expected 12", busy_cnt); end
    n_cmp++; if (err_cnt != 0) begin n_bad++; $display("FAIL single_err: got %0d expected 0", err_cnt); end
    n_cmp++; if (gap_cnt != 0) begin n_bad++; $display("FAIL single_gap: got %0d expected 0", gap_cnt); end
  endtask

  task automatic test_stuff_after_sync();
    run_packet(16'h00FF, 8, 1'b1, 1'b0, -1);
    n_cmp++; if (line_s != "KJKJKJKKKKKKKJJJJ00J") begin n_bad++; $display("FAIL ff_line: got %s expected KJKJKJKKKKKKKJJJJ00J", line_s); end
    n_cmp++; if (gap_cnt != 1) begin n_bad++; $display("FAIL ff_ready_gap: got %0d expected 1", gap_cnt); end
    n_cmp++; if (busy_cnt != 20) begin n_bad++; $display("FAIL ff_busy: got %0d expected 20", busy_cnt); end
    n_cmp++; if (err_cnt != 0) begin n_bad++; $display("FAIL ff_err: got %0d expected 0", err_cnt); end
  endtask

  task automatic test_stuff_on_last();
    run_packet(16'h007E, 7, 1'b1, 1'b0, -1);
    n_cmp++; if (line_s != "KJKJKJKKJJJJJJJK00J") begin n_bad++; $display("FAIL lastst_line: got %s expected KJKJKJKKJJJJJJJK00J", line_s); end
    n_cmp++; if (line_s.len() != 19) begin n_bad++; $display("FAIL lastst_oe: got %0d expected 19", line_s.len()); end
    n_cmp++; if (busy_cnt != 19) begin n_bad++; $display("FAIL lastst_busy: got %0d expected 19", busy_cnt); end
  endtask

  task automatic test_mixed();
    run_packet(16'h003A, 8, 1'b1, 1'b0, -1);
    n_cmp++; if (line_s != "KJKJKJKKJJKKKKJK00J") begin n_bad++; $display("FAIL mixed_line: got %s expected KJKJKJKKJJKKKKJK00J", line_s); end
    n_cmp++; if (gap_cnt != 0) begin n_bad++; $display("FAIL mixed_gap: got %0d expected 0", gap_cnt); end
  endtask

  task automatic test_underrun();
    run_packet(16'h0005, 3, 1'b0, 1'b0, -1);
    n_cmp++; if (line_s != "KJKJKJKKKJJJ00J") begin n_bad++; $display("FAIL under_line: got %s expected KJKJKJKKKJJJ00J", line_s); end
    n_cmp++; if (err_cnt != 1) begin n_bad++; $display("FAIL under_err_cnt: got %0d expected 1", err_cnt); end
    n_cmp++; if (err_pos != 11) begin n_bad++; $display("FAIL under_err_pos: got %0d expected 11", err_pos); end
    n_cmp++; if (busy_cnt != 15) begin n_bad++; $display("FAIL under_busy: got %0d expected 15", busy_cnt); end
  endtask

  task automatic test_reset_mid_data();
    run_packet(16'h0000, 8, 1'b1, 1'b0, 4);
    n_cmp++; if (!reset_hit) begin n_bad++; $display("FAIL midrst_reached: got 0 expected 1"); end
    n_cmp++; if (line_s != "KJKJKJKKJKJK") begin n_bad++; $display("FAIL midrst_pre_line: got %s expected KJKJKJKKJKJK", line_s); end
    n_cmp++; if ({dp, dm, oe, busy, err, bus.in_ready} !== 6'b100000) begin
      n_bad++; $display("FAIL midrst_outputs: got dp/dm/oe/busy/err/rdy=%b expected 100000", {dp, dm, oe, busy, err, bus.in_ready});
    end
    bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.in_last = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if ({oe, dp, dm} !== 3'b010) begin n_bad++; $display("FAIL midrst_no_eop%0d: got oe/dp/dm=%b expected 010", i, {oe, dp, dm}); end
    end
    run_packet(16'h0000, 1, 1'b1, 1'b0, -1);
    n_cmp++; if (line_s != "KJKJKJKKJ00J") begin n_bad++; $display("FAIL midrst_next_line: got %s expected KJKJKJKKJ00J", line_s); end
  endtask

  task automatic test_back_to_back();
    run_packet(16'h0001, 1, 1'b1, 1'b1, -1);
    n_cmp++; if (line_s != "KJKJKJKKK00J") begin n_bad++; $display("FAIL b2b_line: got %s expected KJKJKJKKK00J", line_s); end
    n_cmp++; if (extra_cnt != 0) begin n_bad++; $display("FAIL b2b_consumed: got %0d expected 0", extra_cnt); end
    n_cmp++; if ({oe, dp, dm} !== 3'b010) begin n_bad++; $display("FAIL b2b_idle_gap: got oe/dp/dm=%b expected 010", {oe, dp, dm}); end
    @(negedge clk);
    n_cmp++; if ({oe, dp, dm, busy} !== 4'b1011) begin n_bad++; $display("FAIL b2b_new_sync: got oe/dp/dm/busy=%b expected 1011", {oe, dp, dm, busy}); end
    rst_b = 1'b0;
    bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.in_last = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    $display("txn back_to_back done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_bit();
    test_stuff_after_sync();
    test_stuff_on_last();
    test_mixed();
    test_underrun();
    test_reset_mid_data();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
